da_shift_accumulator: RTL and testbench

- Bit-serial shift-accumulate stage of the DA-based LMS filter datapath.
- Issues bit index `amt` (0..7, LSB first) to the upstream 8-bit rotate-right barrel shifters. Each shifter rotates its tap sample so bit `amt` lands at bit 0; those bits form the DA LUT address.
- Accumulates the returned LUT partial sums with binary weighting and two's-complement sign handling on the MSB slice.
- Emits one filter output word per start request.

---
 rtl/da_shift_accumulator.sv | 101 ++++++++++
 tb/tb_da_shift_accumulator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/da_shift_accumulator.sv
// Bit-serial shift-accumulate stage of the DA LMS filter: walks the slice index
// through the barrel shifters and folds the returned LUT partial sums into one output word.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; amt parked at 0
// ISSUE | amt=j presented to the shifters, amt_valid pulses
// WAIT  | holding amt=j until the LUT returns its partial sum
// DONE  | y carries the finished conversion, y_valid pulses
module da_shift_accumulator #(
  parameter int LUT_W = 12,
  parameter int AMT_W = 3,
  parameter int ACC_W = LUT_W + 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [LUT_W-1:0] lut_in,
  input  logic                    lut_valid,
  output logic [AMT_W-1:0]        amt,
  output logic                    amt_valid,
  output logic                    busy,
  output logic signed [ACC_W-1:0] y,
  output logic                    y_valid
);

  localparam int BITS = 2 ** AMT_W;
  localparam logic [AMT_W-1:0] J_LAST = AMT_W'(BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [AMT_W-1:0]         j_q, j_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  y_q, y_d;
  logic signed [ACC_W-1:0]  lut_ext;
  logic signed [ACC_W-1:0]  term;
  logic                     slice_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  end

  assign slice_ok = (state_q == S_WAIT) && lut_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (lut_valid) state_d = (j_q == J_LAST) ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The MSB slice carries negative binary weight, so it is subtracted.
  always_comb begin
    lut_ext = {{(ACC_W - LUT_W){lut_in[LUT_W-1]}}, lut_in};
    term    = lut_ext << j_q;
    j_d     = j_q;
    acc_d   = acc_q;
    y_d     = y_q;
    if (state_q == S_IDLE && start) begin
      j_d   = '0;
      acc_d = '0;
    end else if (slice_ok) begin
      if (j_q == J_LAST) begin
        acc_d = acc_q - term;
        y_d   = acc_q - term;
      end else begin
        acc_d = acc_q + term;
        j_d   = j_q + AMT_W'(1);
      end
    end
  end

  always_comb begin
    amt       = (state_q == S_IDLE) ? '0 : j_q;
    amt_valid = (state_q == S_ISSUE);
    busy      = (state_q != S_IDLE);
    y_valid   = (state_q == S_DONE);
    y         = y_q;
  end

endmodule

// File: tb/tb_da_shift_accumulator.sv
// Self-checking bench for da_shift_accumulator: table vectors, abort/back-to-back
// sequences and randomized conversions against an arithmetic reference.
module tb_da_shift_accumulator;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic signed [11:0] lut_in;
  logic               lut_valid;
  logic [2:0]         amt;
  logic               amt_valid;
  logic               busy;
  logic signed [19:0] y;
  logic               y_valid;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  da_shift_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .lut_in    (lut_in),
    .lut_valid (lut_valid),
    .amt       (amt),
    .amt_valid (amt_valid),
    .busy      (busy),
    .y         (y),
    .y_valid   (y_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    v [8];
    int    stall_j;
    int    stall_n;
    bit    spur;
    int    exp_y;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: two's-complement bit-serial sum, MSB slice negatively weighted.
  function automatic int model(input int v [8]);
    int s = 0;
    for (int j = 0; j < 7; j++) s += v[j] * (1 << j);
    s -= v[7] * 128;
    return s;
  endfunction

  // Starts a conversion from IDLE, acts as the LUT, returns in IDLE after DONE
  // (or in ISSUE of slice abort_j when aborting).
  task automatic do_conv(input int v [8], input int stall_j, input int stall_n,
                         input bit spur, input bit hold, input int abort_j,
                         output int y_got, output int lat, output int t_done,
                         output bit seq_ok, output bit aborted);
    int idx = 0;
    bit pend = 0;
    int stl = 0;
    int t0;
    bit done = 0;
    int word;
    seq_ok = 1; aborted = 0; y_got = 0; lat = -1; t_done = -1;
    start = 1'b1;
    t0 = cyc;
    step();
    for (int k = 1; k <= 100 && !done; k++) begin
      if (!hold) start = 1'b0;
      lut_valid = 1'b0;
      if (amt_valid) begin
        if (int'(amt) != idx || y_valid || !busy) seq_ok = 0;
        if (idx == abort_j) begin
          aborted = 1; done = 1;
        end else begin
          pend = 1;
          stl  = (idx == stall_j) ? stall_n : 0;
          if (spur) begin start = 1'b1; lut_valid = 1'b1; lut_in = 12'sh5A5; end
        end
      end else if (y_valid) begin
        y_got  = int'(y);
        lat    = cyc - t0;
        t_done = cyc;
        done   = 1;
        if (!busy || idx != 8) seq_ok = 0;
      end else if (pend) begin
        if (!busy || int'(amt) != idx) seq_ok = 0;
        if (stl > 0) stl--;
        else begin
          word = v[idx];
          lut_valid = 1'b1;
          lut_in = word[11:0];
          pend = 0;
          idx++;
        end
      end else begin
        seq_ok = 0;
      end
      if (!done) step();
    end
    if (!done) $display("FAIL conv_timeout: got no y_valid, expected one within 100 cycles");
    if (!aborted) begin
      lut_valid = 1'b0;
      step();
    end
  endtask

  vec_t tbl [6];

  initial begin
    int  y_got, lat, t_done, t_first;
    bit  seq_ok, aborted, idle_ok;
    int  v [8];
    int  ones [8];
    int  sn, sj;

    tbl[0] = '{"const5",   '{5, 5, 5, 5, 5, 5, 5, 5},             -1, 0, 0, -5};
    tbl[1] = '{"j0_3",     '{3, 0, 0, 0, 0, 0, 0, 0},             -1, 0, 0, 3};
    tbl[2] = '{"j7_7",     '{0, 0, 0, 0, 0, 0, 0, 7},             -1, 0, 0, -896};
    tbl[3] = '{"j7_min",   '{0, 0, 0, 0, 0, 0, 0, -2048},         -1, 0, 0, 262144};
    tbl[4] = '{"mix",      '{10, -20, 30, -40, 50, -60, 70, -80}, -1, 0, 0, 13370};
    tbl[5] = '{"mix_stall",'{10, -20, 30, -40, 50, -60, 70, -80},  3, 5, 1, 13370};
    for (int i = 0; i < 8; i++) ones[i] = 1;

    rst_n = 1'b1; start = 1'b0; lut_in = '0; lut_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_amt", int'(amt), 0);
    chk("rst_flags", {amt_valid, busy, y_valid}, 0);
    chk("rst_y", int'(y), 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    idle_ok = 1;
    for (int i = 0; i < 20; i++) begin
      if (busy || amt_valid || y_valid) idle_ok = 0;
      step();
    end
    chk("idle_quiet", idle_ok, 1);

    foreach (tbl[i]) begin
      do_conv(tbl[i].v, tbl[i].stall_j, tbl[i].stall_n, tbl[i].spur, 1'b0, -1,
              y_got, lat, t_done, seq_ok, aborted);
      chk({tbl[i].name, "_y"}, y_got, tbl[i].exp_y);
      chk({tbl[i].name, "_lat"}, lat, 17 + tbl[i].stall_n);
      chk({tbl[i].name, "_seq"}, seq_ok, 1);
      chk({tbl[i].name, "_hold"}, int'(y), tbl[i].exp_y);
      chk({tbl[i].name, "_idle"}, {busy, amt_valid, y_valid, amt}, 0);
    end

    // abort at slice 4 with a nonzero partial accumulation already present
    do_conv(tbl[4].v, -1, 0, 1'b0, 1'b0, 4, y_got, lat, t_done, seq_ok, aborted);
    chk("abort_reached", aborted, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outs", {busy, amt_valid, y_valid, amt}, 0);
    chk("abort_y", int'(y), 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    do_conv(ones, -1, 0, 1'b0, 1'b0, -1, y_got, lat, t_done, seq_ok, aborted);
    chk("restart_y", y_got, -1);
    chk("restart_lat", lat, 17);

    // back-to-back with start held high
    for (int i = 0; i < 8; i++) v[i] = $urandom_range(4095) - 2048;
    do_conv(v, -1, 0, 1'b0, 1'b1, -1, y_got, lat, t_done, seq_ok, aborted);
    chk("b2b_a_y", y_got, model(v));
    t_first = t_done;
    for (int i = 0; i < 8; i++) v[i] = $urandom_range(4095) - 2048;
    do_conv(v, -1, 0, 1'b0, 1'b1, -1, y_got, lat, t_done, seq_ok, aborted);
    chk("b2b_b_y", y_got, model(v));
    chk("b2b_gap", t_done - t_first, 18);
    chk("b2b_seq", seq_ok, 1);
    start = 1'b0;
    step();
    step();
    chk("b2b_idle", busy, 0);

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 8; i++) v[i] = $urandom_range(4095) - 2048;
      sj = $urandom_range(7);
      sn = $urandom_range(3);
      do_conv(v, sj, sn, r[0], 1'b0, -1, y_got, lat, t_done, seq_ok, aborted);
      chk("rand_y", y_got, model(v));
      chk("rand_lat", lat, 17 + sn);
      chk("rand_seq", seq_ok, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
